// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - unsigned restoring shift/subtract divider, one quotient bit per clock
module shift_sub_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             rdy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    // One-hot so busy/rdy are single flop bits with no decode glitches.
    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_CALC = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    logic [2:0]       state;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sh_r;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] nxt_r;
    logic [WIDTH-1:0] nxt_q;
    logic             accept;
    logic             last_iter;

    assign accept    = run && ((state == S_IDLE) || (state == S_DONE));
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign busy      = state[1];
    assign rdy       = state[2];

    // One restoring step: shift {R,Q} left, keep the subtraction only if it did not go negative.
    always_comb begin
        sh_r  = {acc_r, shift_q[WIDTH-1]};
        trial = sh_r - {1'b0, dvs_r};
        nxt_r = sh_r[WIDTH-1:0];
        nxt_q = {shift_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            nxt_r = trial[WIDTH-1:0];
            nxt_q = {shift_q[WIDTH-2:0], 1'b1};
        end
    end

    // Control, datapath and result registers; results only change on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            acc_r       <= '0;
            shift_q     <= '0;
            dvs_r       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        dvs_r   <= divisor;
                        acc_r   <= '0;
                        shift_q <= dividend;
                        cnt     <= '0;
                        if (divisor == '0) begin
                            // Nothing to iterate: report saturated quotient straight away.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            state       <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_r   <= nxt_r;
                    shift_q <= nxt_q;
                    if (last_iter) begin
                        quotient  <= nxt_q;
                        remainder <= nxt_r;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
